vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  VGA 640x480@60Hz timing generator and pixel output stage, clocked by the 25 MHz pixel clock.
//  Generates active-low hsync/vsync and a 'valid' active-video strobe. The top level advances
//  its frame-buffer read address on 'valid'. Expands the 8-bit RGB332 pixel read from the
//  frame buffer to the 4:4:4 DAC outputs.
// PARAMETERS
//  H_ACTIVE 640  visible pixels/line      | H_FP 16  | H_SYNC 96  | H_BP 48  (H_TOTAL = 800)
//  V_ACTIVE 480  visible lines/frame      | V_FP 10  | V_SYNC 2   | V_BP 33  (V_TOTAL = 525)
// PORTS
//  clk      in   1  pixel clock, 25 MHz; all logic on rising edge
//  rst      in   1  asynchronous, active-high reset
//  data_in  in   8  RGB332 pixel {R[2:0],G[2:0],B[1:0]} for the current pixel
//  hsync    out  1  horizontal sync, active low
//  vsync    out  1  vertical sync, active low
//  valid    out  1  high while (h_cnt,v_cnt) is inside the 640x480 active area
//  vga_r    out  4  red   = {data_in[7:5], data_in[7]}   when valid, else 0
//  vga_g    out  4  green = {data_in[4:2], data_in[4]}   when valid, else 0
//  vga_b    out  4  blue  = {data_in[1:0], data_in[1:0]} when valid, else 0
// BEHAVIOUR
//  - Counters: h_cnt 10b 0..799, v_cnt 10b 0..524, both registered.
//  - Counter update: h_cnt increments every clk. At 799 it wraps to 0.
//    v_cnt increments only when h_cnt wraps. v_cnt wraps 524->0 when h_cnt wraps at v_cnt=524.
//  - Reset: rst high clears h_cnt = v_cnt = 0 immediately (async).
//    While rst is high, outputs are forced to hsync=1, vsync=1, valid=0, vga_r/g/b=0.
//  - Reset mid-frame: same forcing applies. Timing restarts at (0,0) on the first clk after release.
//  - Decodes: combinational from the registered counters, so they have zero latency vs. the counters.
//    valid = (h_cnt < 640) && (v_cnt < 480)
//    hsync = ~((h_cnt >= 656) && (h_cnt <= 751))
//    vsync = ~((v_cnt >= 490) && (v_cnt <= 491))
//  - Colour: combinational from data_in gated by valid, with no pipeline stage.
//    Frame-buffer read latency is absorbed by the top level (address advanced on valid).
//  - Per frame: 420000 clocks, exactly 307200 valid cycles. hsync low 96 clocks/line.
//    vsync low for 2 full lines (1600 clocks).
//  - Outside the active area all colour outputs are 0, regardless of data_in.
//  - No handshake: data_in is sampled/used every cycle. Behaviour does not depend on data_in timing.
// TESTING
//  1 Reset: hold rst, data_in=8'hFF -> hsync=1, vsync=1, valid=0, rgb=0.
//    Release -> valid=1 on the first cycle at (0,0).
//  2 Line timing: count from reset release -> valid high for clocks 0..639 of each line.
//    hsync low for clocks 656..751. Line period 800.
//  3 Frame timing: run 2 frames -> exactly 307200 valid cycles per frame.
//    vsync low on lines 490-491 only. Frame period 420000 clocks.
//  4 Colour mapping: data_in=8'hE0 in active area -> r=4'hF, g=0, b=0.
//    8'h1C -> g=4'hF. 8'h03 -> b=4'hF. 8'hFF -> r=g=b=4'hF.
//    8'hE0 during blanking -> rgb=0.
//  5 Wrap boundary: at h_cnt=799, v_cnt=524 -> next clk (0,0), valid=1, vsync=1.
//  6 Mid-frame reset at v_cnt=300 -> outputs forced immediately.
//    Counting restarts from (0,0) after release.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
//   VGA timing generator and pixel output stage, clocked by the pixel clock.
//   The default geometry is 640x480@60Hz on a 25 MHz pixel clock.
//   A free-running horizontal/vertical counter pair is decoded into active-low
//   sync pulses and an active-video strobe. The RGB332 frame-buffer pixel is
//   expanded to three 4-bit DAC channels, and blanked outside the active area.
//
// Ports
//   clk      in   1  pixel clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   data_in  in   8  RGB332 pixel {R[2:0],G[2:0],B[1:0]} for the current pixel
//   hsync    out  1  horizontal sync, active low
//   vsync    out  1  vertical sync, active low
//   valid    out  1  high while the counters are inside the active area
//   vga_r    out  4  red DAC value   (0 outside the active area)
//   vga_g    out  4  green DAC value (0 outside the active area)
//   vga_b    out  4  blue DAC value  (0 outside the active area)
// -----------------------------------------------------------------------------
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode thresholds held at counter width so every compare is 10 bits.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       active;

  // Bit replication maps the full-scale 3-bit/2-bit codes onto full-scale
  // 4-bit DAC codes (max in -> 4'hF, zero in -> 4'h0).
  function automatic logic [3:0] expand3(input logic [2:0] c);
    return {c, c[2]};
  endfunction

  function automatic logic [3:0] expand2(input logic [1:0] c);
    return {c, c};
  endfunction

  // ---- counter stage: h_cnt every clock, v_cnt on each h_cnt wrap ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // ---- decode / output stage: combinational from the registered counters ----
  // The counters already sit at (0,0) during reset, so the decodes are
  // explicitly forced to their idle levels while rst is high.
  always_comb begin
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    valid  = ~rst & active;
    hsync  = rst | ~((h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END));
    vsync  = rst | ~((v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END));
    vga_r  = valid ? expand3(data_in[7:5]) : 4'h0;
    vga_g  = valid ? expand3(data_in[4:2]) : 4'h0;
    vga_b  = valid ? expand2(data_in[1:0]) : 4'h0;
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_ctrl
//   Testbench for vga_timing_ctrl. One instance runs the full 640x480 geometry
//   (reset, line timing, colour mapping); a second instance with a scaled-down
//   geometry (30 clocks/line, 19 lines/frame) makes whole-frame timing, the
//   frame wrap and the mid-frame reset reachable in a short run. Both share
//   clk, rst and data_in. Expected outputs come from a bench-side counter model
//   and are queued per cycle, then popped and compared against the DUTs.
// -----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;

  logic       hsync_d, vsync_d, valid_d;
  logic [3:0] r_d, g_d, b_d;
  logic       hsync_s, vsync_s, valid_s;
  logic [3:0] r_s, g_s, b_s;

  vga_timing_ctrl dut (
    .clk(clk), .rst(rst), .data_in(data_in),
    .hsync(hsync_d), .vsync(vsync_d), .valid(valid_d),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk(clk), .rst(rst), .data_in(data_in),
    .hsync(hsync_s), .vsync(vsync_s), .valid(valid_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vl;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } exp_t;

  typedef struct packed {
    exp_t d;
    exp_t s;
  } sb_t;

  sb_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  // bench model counters (default geometry, scaled geometry)
  int hm = 0, vm = 0, hsm = 0, vsm = 0;

  // observations captured at the sample point of the last cycle
  logic       ob_valid_d, ob_hs_d, ob_valid_s, ob_hs_s, ob_vs_s;
  logic [3:0] ob_r_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int h, input int v, input logic r_, input logic [7:0] d,
                                 input int ha, input int hfp, input int hsy,
                                 input int va, input int vfp, input int vsy);
    exp_t e;
    e.vl = !r_ && (h < ha) && (v < va);
    e.hs = r_ || !((h >= ha + hfp) && (h < ha + hfp + hsy));
    e.vs = r_ || !((v >= va + vfp) && (v < va + vfp + vsy));
    e.r  = e.vl ? {d[7:5], d[7]} : 4'h0;
    e.g  = e.vl ? {d[4:2], d[4]} : 4'h0;
    e.b  = e.vl ? {d[1:0], d[1:0]} : 4'h0;
    return e;
  endfunction

  // One pixel clock: drive at the falling edge, sample 1 ns later, then let
  // the model follow the DUT counters across the rising edge.
  task automatic cycle(input logic r, input logic [7:0] d);
    sb_t e;
    sb_t o;
    @(negedge clk);
    rst     = r;
    data_in = d;
    if (r) begin
      hm = 0; vm = 0; hsm = 0; vsm = 0;
    end
    e.d = model(hm, vm, r, d, 640, 16, 96, 480, 10, 2);
    e.s = model(hsm, vsm, r, d, 16, 4, 6, 12, 2, 2);
    sbq.push_back(e);
    #1;
    o = sbq.pop_front();
    chk("d_hsync", 32'(hsync_d), 32'(o.d.hs));
    chk("d_vsync", 32'(vsync_d), 32'(o.d.vs));
    chk("d_valid", 32'(valid_d), 32'(o.d.vl));
    chk("d_red",   32'(r_d),     32'(o.d.r));
    chk("d_green", 32'(g_d),     32'(o.d.g));
    chk("d_blue",  32'(b_d),     32'(o.d.b));
    chk("s_hsync", 32'(hsync_s), 32'(o.s.hs));
    chk("s_vsync", 32'(vsync_s), 32'(o.s.vs));
    chk("s_valid", 32'(valid_s), 32'(o.s.vl));
    chk("s_red",   32'(r_s),     32'(o.s.r));
    chk("s_green", 32'(g_s),     32'(o.s.g));
    chk("s_blue",  32'(b_s),     32'(o.s.b));
    ob_valid_d = valid_d;
    ob_hs_d    = hsync_d;
    ob_valid_s = valid_s;
    ob_hs_s    = hsync_s;
    ob_vs_s    = vsync_s;
    ob_r_s     = r_s;
    @(posedge clk);
    if (!r) begin
      if (hm == 799) begin
        hm = 0;
        vm = (vm == 524) ? 0 : vm + 1;
      end else begin
        hm = hm + 1;
      end
      if (hsm == 29) begin
        hsm = 0;
        vsm = (vsm == 18) ? 0 : vsm + 1;
      end else begin
        hsm = hsm + 1;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   dl_v[3];
    int   dl_h[3];
    int   sf_v[2];
    int   sf_vs[2];
    int   sf_h[2];
    int   hs_fall[$];
    int   vs_fall[$];
    logic prev_hs_d;
    logic prev_vs_s;
    logic [7:0] d;
    logic found;

    foreach (dl_v[k]) begin dl_v[k] = 0; dl_h[k] = 0; end
    foreach (sf_v[k]) begin sf_v[k] = 0; sf_vs[k] = 0; sf_h[k] = 0; end
    prev_hs_d = 1'b1;
    prev_vs_s = 1'b1;

    // reset held with an all-ones pixel: outputs idle
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hFF);
    chk("rst_valid", 32'(ob_valid_d), 32'd0);
    chk("rst_hsync", 32'(ob_hs_d), 32'd1);

    // free run: three full default lines, four scaled frames
    for (int i = 0; i < 2400; i++) begin
      case (i % 5)
        0:       d = 8'hE0;
        1:       d = 8'h1C;
        2:       d = 8'h03;
        3:       d = 8'hFF;
        default: d = 8'($urandom_range(0, 255));
      endcase
      cycle(1'b0, d);
      if (i == 0) begin
        chk("release_valid_d", 32'(ob_valid_d), 32'd1);
        chk("release_valid_s", 32'(ob_valid_s), 32'd1);
      end
      if (i == 570) begin
        chk("wrap_valid", 32'(ob_valid_s), 32'd1);
        chk("wrap_vsync", 32'(ob_vs_s), 32'd1);
      end
      dl_v[i / 800] += int'(ob_valid_d);
      dl_h[i / 800] += int'(!ob_hs_d);
      if (i < 1140) begin
        sf_v[i / 570]  += int'(ob_valid_s);
        sf_vs[i / 570] += int'(!ob_vs_s);
        sf_h[i / 570]  += int'(!ob_hs_s);
      end
      if (prev_hs_d && !ob_hs_d) hs_fall.push_back(i);
      if (prev_vs_s && !ob_vs_s) vs_fall.push_back(i);
      prev_hs_d = ob_hs_d;
      prev_vs_s = ob_vs_s;
    end

    for (int l = 0; l < 3; l++) begin
      chk("line_valid_count", 32'(dl_v[l]), 32'd640);
      chk("line_hsync_low",   32'(dl_h[l]), 32'd96);
    end
    for (int f = 0; f < 2; f++) begin
      chk("frame_valid_count", 32'(sf_v[f]),  32'd192);
      chk("frame_vsync_low",   32'(sf_vs[f]), 32'd60);
      chk("frame_hsync_low",   32'(sf_h[f]),  32'd114);
    end
    chk("hsync_fall_count", 32'(hs_fall.size()), 32'd3);
    if (hs_fall.size() >= 2) begin
      chk("hsync_first_fall", 32'(hs_fall[0]), 32'd656);
      chk("line_period", 32'(hs_fall[1] - hs_fall[0]), 32'd800);
    end
    chk("vsync_fall_count", 32'(vs_fall.size()), 32'd4);
    if (vs_fall.size() >= 2) begin
      chk("vsync_first_fall", 32'(vs_fall[0]), 32'd420);
      chk("frame_period", 32'(vs_fall[1] - vs_fall[0]), 32'd570);
    end

    // mid-frame reset on the scaled instance at line 7, pixel 10
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (vsm == 7 && hsm == 10) found = 1'b1;
      else cycle(1'b0, 8'($urandom_range(0, 255)));
    end
    chk("seek_mid_frame", 32'(found), 32'd1);
    cycle(1'b1, 8'hE0);
    chk("mid_rst_valid", 32'(ob_valid_s), 32'd0);
    chk("mid_rst_hsync", 32'(ob_hs_s), 32'd1);
    chk("mid_rst_red",   32'(ob_r_s), 32'd0);
    cycle(1'b1, 8'hE0);
    cycle(1'b1, 8'hE0);
    cycle(1'b0, 8'hE0);
    chk("restart_valid", 32'(ob_valid_s), 32'd1);
    chk("restart_red",   32'(ob_r_s), 32'd15);
    for (int i = 0; i < 60; i++) cycle(1'b0, 8'($urandom_range(0, 255)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
